// File: rtl/s2_kes_ibm_param.sv
// ---------------------------------------------------------------------------
// s2_kes_ibm_param -- inversionless Berlekamp-Massey key-equation solver,
// second stage of the RS decoder, for any correction capability T (1..8).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   kes_ena    start request, only looked at while idle
//   rs_syn     2T syndromes, S_j = rs_syn[8j+7:8j]
//   kes_busy   high from the accept edge until the kes_done cycle (exclusive)
//   rs_lambda  error locator, Lambda_i = rs_lambda[8i+7:8i], scaled by a nonzero constant
//   rs_omega   error evaluator, Omega_j = rs_omega[8j+7:8j], same scale as Lambda
//   rs_deg     final BM register length L
//   kes_fail   L > T, pattern not correctable
//   kes_done   one-cycle pulse, results valid from this cycle and held until the next pulse
//
// Also contains gf2m8_multi, the combinational GF(2^8) multiplier
// (field polynomial x^8+x^4+x^3+x^2+1).
// ---------------------------------------------------------------------------

module gf2m8_multi (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);
    logic [7:0] acc;
    logic [7:0] sh;

    // Shift-and-add: sh walks through a*x^n reduced modulo the field polynomial.
    always_comb begin
        acc = 8'h00;
        sh  = a;
        for (int n = 0; n < 8; n++) begin
            if (b[n]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1D : 8'h00);
        end
        p = acc;
    end
endmodule

module s2_kes_ibm_param #(
    parameter int T  = 2,
    parameter int LW = $clog2(2*T+1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 kes_ena,
    input  logic [16*T-1:0]      rs_syn,
    output logic                 kes_busy,
    output logic [8*(T+1)-1:0]   rs_lambda,
    output logic [8*T-1:0]       rs_omega,
    output logic [LW-1:0]        rs_deg,
    output logic                 kes_fail,
    output logic                 kes_done
);
    typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIN = 2'd2, BYP = 2'd3} state_t;

    state_t          state_reg, state_next;
    logic [16*T-1:0] syn_reg;
    logic [7:0]      lambda_reg [0:T];
    // B only needs T coefficients: x*B is truncated at degree T, so the top one never matters.
    logic [7:0]      b_reg      [0:T-1];
    logic [7:0]      gamma_reg;
    logic [LW-1:0]   l_reg, k_reg;

    logic [7:0]      lambda_next [0:T];
    logic [7:0]      b_next      [0:T-1];
    logic [7:0]      dl_prod     [0:T];
    logic [7:0]      gl_prod     [0:T];
    logic [7:0]      db_prod     [0:T];
    logic [7:0]      om_prod     [0:T-1][0:T-1];
    logic [7:0]      omega_val   [0:T-1];
    logic [7:0]      delta;
    logic [LW-1:0]   l_next;
    logic            do_swap, last_iter, iter_en;

    assign kes_busy  = (state_reg != IDLE);
    assign last_iter = (k_reg == LW'(2*T-1));
    // Clock enable for the iteration registers: active while busy or accepting.
    assign iter_en   = kes_busy || kes_ena;

    // ---------------- control ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (kes_ena) state_next = (rs_syn == '0) ? BYP : ITER;
            ITER: if (last_iter) state_next = FIN;
            FIN:  state_next = IDLE;
            BYP:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // ---------------- BM datapath ----------------
    genvar gi, gj;
    generate
        for (gi = 0; gi <= T; gi++) begin : g_coef
            logic [7:0] sel;
            // S_{k-gi}, or zero when gi > k (term not yet in the discrepancy sum).
            always_comb begin
                sel = 8'h00;
                for (int j = 0; j < 2*T - gi; j++) begin
                    if (k_reg == LW'(j + gi)) sel = syn_reg[8*j +: 8];
                end
            end
            gf2m8_multi u_dl (.a(lambda_reg[gi]), .b(sel),            .p(dl_prod[gi]));
            gf2m8_multi u_gl (.a(gamma_reg),      .b(lambda_reg[gi]), .p(gl_prod[gi]));
            if (gi == 0) begin : g_lo
                assign db_prod[gi] = 8'h00;
                assign b_next[gi]  = do_swap ? lambda_reg[gi] : 8'h00;
            end else begin : g_hi
                gf2m8_multi u_db (.a(delta), .b(b_reg[gi-1]), .p(db_prod[gi]));
                if (gi < T) begin : g_b
                    assign b_next[gi] = do_swap ? lambda_reg[gi] : b_reg[gi-1];
                end
            end
            assign lambda_next[gi] = gl_prod[gi] ^ db_prod[gi];
        end

        // Omega_j = sum_{i<=j} Lambda_i * S_{j-i}, from the final Lambda.
        for (gj = 0; gj < T; gj++) begin : g_om_row
            for (gi = 0; gi < T; gi++) begin : g_om_col
                if (gi <= gj) begin : g_term
                    gf2m8_multi u_om (.a(lambda_reg[gi]), .b(syn_reg[8*(gj-gi) +: 8]),
                                      .p(om_prod[gj][gi]));
                end else begin : g_zero
                    assign om_prod[gj][gi] = 8'h00;
                end
            end
        end
    endgenerate

    always_comb begin
        delta = 8'h00;
        for (int i = 0; i <= T; i++) delta = delta ^ dl_prod[i];
    end

    always_comb begin
        for (int j = 0; j < T; j++) begin
            omega_val[j] = 8'h00;
            for (int i = 0; i < T; i++) omega_val[j] = omega_val[j] ^ om_prod[j][i];
        end
    end

    // Length change only when delta != 0 and 2L <= k (one extra bit avoids overflow of 2L).
    assign do_swap = (delta != 8'h00) && ({l_reg, 1'b0} <= {1'b0, k_reg});
    assign l_next  = k_reg + LW'(1) - l_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            syn_reg   <= '0;
            gamma_reg <= 8'h00;
            l_reg     <= '0;
            k_reg     <= '0;
            for (int i = 0; i <= T; i++) lambda_reg[i] <= 8'h00;
            for (int i = 0; i < T; i++)  b_reg[i]      <= 8'h00;
        end else if (iter_en) begin
            case (state_reg)
                IDLE: begin
                    syn_reg   <= rs_syn;
                    gamma_reg <= 8'h01;
                    l_reg     <= '0;
                    k_reg     <= '0;
                    for (int i = 0; i <= T; i++) lambda_reg[i] <= (i == 0) ? 8'h01 : 8'h00;
                    for (int i = 0; i < T; i++)  b_reg[i]      <= (i == 0) ? 8'h01 : 8'h00;
                end
                ITER: begin
                    for (int i = 0; i <= T; i++) lambda_reg[i] <= lambda_next[i];
                    for (int i = 0; i < T; i++)  b_reg[i]      <= b_next[i];
                    if (do_swap) begin
                        gamma_reg <= delta;
                        l_reg     <= l_next;
                    end
                    k_reg <= last_iter ? '0 : k_reg + LW'(1);
                end
                default: ;
            endcase
        end
    end

    // ---------------- result registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_lambda <= '0;
            rs_omega  <= '0;
            rs_deg    <= '0;
            kes_fail  <= 1'b0;
            kes_done  <= 1'b0;
        end else begin
            kes_done <= 1'b0;
            if (state_reg == FIN) begin
                for (int i = 0; i <= T; i++) rs_lambda[8*i +: 8] <= lambda_reg[i];
                for (int j = 0; j < T; j++)  rs_omega[8*j +: 8]  <= omega_val[j];
                rs_deg   <= l_reg;
                kes_fail <= (l_reg > LW'(T));
                kes_done <= 1'b1;
            end else if (state_reg == BYP) begin
                rs_lambda <= {{(8*T){1'b0}}, 8'h01};
                rs_omega  <= '0;
                rs_deg    <= '0;
                kes_fail  <= 1'b0;
                kes_done  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_s2_kes_ibm_param.sv
// ---------------------------------------------------------------------------
// tb_s2_kes_ibm_param -- self-checking bench for s2_kes_ibm_param.
// Two instances (T=2 and T=3). Random error patterns of weight <= T are turned
// into syndromes with log/antilog GF tables; the expected locator is the
// product of (1 + X_i x) and the expected evaluator is S(x)*Lambda(x) mod x^T.
// Since the solver output carries an arbitrary nonzero scale, random results
// are compared after scaling the expected polynomials by the returned Lambda_0.
// Latency is counted in rising edges after the accept edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_s2_kes_ibm_param;
    logic clk = 1'b0;
    logic rst;

    logic        ena2, busy2, fail2, done2;
    logic [31:0] syn2;
    logic [23:0] lam2;
    logic [15:0] om2;
    logic [2:0]  deg2;

    logic        ena3, busy3, fail3, done3;
    logic [47:0] syn3;
    logic [31:0] lam3;
    logic [23:0] om3;
    logic [2:0]  deg3;

    int          t_sel;
    logic [71:0] cur_lam;
    logic [63:0] cur_om;
    logic [2:0]  cur_deg;
    logic        cur_busy, cur_done, cur_fail;

    int total = 0;
    int bad   = 0;

    logic [7:0] gexp [0:254];
    int         glog [0:255];
    logic [7:0] m_syn [0:15];
    logic [7:0] m_lam [0:8];
    logic [7:0] m_om  [0:7];

    s2_kes_ibm_param #(.T(2)) dut2 (
        .clk(clk), .rst(rst), .kes_ena(ena2), .rs_syn(syn2), .kes_busy(busy2),
        .rs_lambda(lam2), .rs_omega(om2), .rs_deg(deg2), .kes_fail(fail2), .kes_done(done2)
    );
    s2_kes_ibm_param #(.T(3)) dut3 (
        .clk(clk), .rst(rst), .kes_ena(ena3), .rs_syn(syn3), .kes_busy(busy3),
        .rs_lambda(lam3), .rs_omega(om3), .rs_deg(deg3), .kes_fail(fail3), .kes_done(done3)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (t_sel == 3) begin
            cur_lam = {40'b0, lam3}; cur_om = {40'b0, om3}; cur_deg = deg3;
            cur_busy = busy3; cur_done = done3; cur_fail = fail3;
        end else begin
            cur_lam = {48'b0, lam2}; cur_om = {48'b0, om2}; cur_deg = deg2;
            cur_busy = busy2; cur_done = done2; cur_fail = fail2;
        end
    end

    // ---------------- GF reference ----------------
    task automatic init_tables();
        logic [7:0] v;
        v = 8'h01;
        glog[0] = 0;
        for (int n = 0; n < 255; n++) begin
            gexp[n] = v;
            glog[v] = n;
            v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1D : 8'h00);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    // Random error pattern of weight nerr; fills m_syn, m_lam (monic), m_om.
    task automatic make_case(input int t, input int nerr);
        int         locs [0:7];
        int         loc;
        bit         dup;
        logic [7:0] x, y;
        logic [7:0] tmp [0:8];
        for (int i = 0; i < 16; i++) m_syn[i] = 8'h00;
        for (int i = 0; i < 9; i++)  m_lam[i] = 8'h00;
        m_lam[0] = 8'h01;
        for (int e = 0; e < nerr; e++) begin
            loc = 0;
            for (int tries = 0; tries < 100; tries++) begin
                loc = $urandom_range(0, 254);
                dup = 1'b0;
                for (int q = 0; q < e; q++) if (locs[q] == loc) dup = 1'b1;
                if (!dup) break;
            end
            locs[e] = loc;
            y = 8'($urandom_range(1, 255));
            x = gexp[loc];
            for (int j = 0; j < 2*t; j++) m_syn[j] = m_syn[j] ^ gmul(y, gexp[(loc*j) % 255]);
            for (int i = 0; i < 9; i++) tmp[i] = m_lam[i];
            for (int i = 1; i < 9; i++) m_lam[i] = tmp[i] ^ gmul(x, tmp[i-1]);
        end
        for (int j = 0; j < t; j++) begin
            m_om[j] = 8'h00;
            for (int i = 0; i <= j; i++) m_om[j] = m_om[j] ^ gmul(m_lam[i], m_syn[j-i]);
        end
    endtask

    // Drive one job and wait (bounded) for kes_done; lat = edges after accept, -1 on timeout.
    task automatic run_job(input int t, input logic [127:0] syn, output int lat, output bit busy_ok);
        t_sel = t;
        @(negedge clk);
        if (t == 3) begin syn3 = syn[47:0]; ena3 = 1'b1; end
        else        begin syn2 = syn[31:0]; ena2 = 1'b1; end
        @(posedge clk); #1;
        ena2 = 1'b0; ena3 = 1'b0;
        busy_ok = cur_busy;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (cur_done) begin
                lat = n;
                if (cur_busy) busy_ok = 1'b0;
                break;
            end
            if (!cur_busy) busy_ok = 1'b0;
        end
        $display("job t=%0d lat=%0d lambda=%h omega=%h deg=%0d fail=%0b",
                 t, lat, cur_lam, cur_om, cur_deg, cur_fail);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy2 !== 1'b0 || done2 !== 1'b0 || fail2 !== 1'b0) begin bad++;
            $display("FAIL reset_flags2: busy=%b done=%b fail=%b expected 0", busy2, done2, fail2); end
        total++; if (lam2 !== 24'h0 || om2 !== 16'h0 || deg2 !== 3'd0) begin bad++;
            $display("FAIL reset_data2: lambda=%h omega=%h deg=%0d expected 0", lam2, om2, deg2); end
        total++; if (busy3 !== 1'b0 || done3 !== 1'b0 || lam3 !== 32'h0 || om3 !== 24'h0) begin bad++;
            $display("FAIL reset3: busy=%b done=%b lambda=%h omega=%h expected 0", busy3, done3, lam3, om3); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_bypass();
        int lat; bit bok;
        run_job(2, 128'h0, lat, bok);
        total++; if (lat !== 1) begin bad++; $display("FAIL bypass_latency: got %0d expected 1", lat); end
        total++; if (bok !== 1'b1) begin bad++; $display("FAIL bypass_busy: got %b expected 1", bok); end
        total++; if (lam2 !== 24'h000001) begin bad++; $display("FAIL bypass_lambda: got %h expected 000001", lam2); end
        total++; if (om2 !== 16'h0 || deg2 !== 3'd0 || fail2 !== 1'b0) begin bad++;
            $display("FAIL bypass_rest: omega=%h deg=%0d fail=%b expected 0/0/0", om2, deg2, fail2); end
    endtask

    task automatic test_single_t2();
        int lat; bit bok;
        run_job(2, 128'h01010101, lat, bok);
        total++; if (lat !== 5) begin bad++; $display("FAIL single_latency: got %0d expected 5", lat); end
        total++; if (bok !== 1'b1) begin bad++; $display("FAIL single_busy: got %b expected 1", bok); end
        total++; if (lam2 !== 24'h000101) begin bad++; $display("FAIL single_lambda: got %h expected 000101", lam2); end
        total++; if (om2 !== 16'h0001) begin bad++; $display("FAIL single_omega: got %h expected 0001", om2); end
        total++; if (deg2 !== 3'd1 || fail2 !== 1'b0) begin bad++;
            $display("FAIL single_deg: deg=%0d fail=%b expected 1/0", deg2, fail2); end
    endtask

    task automatic test_uncorrectable();
        int lat; bit bok;
        run_job(2, 128'h01000000, lat, bok);
        total++; if (lat !== 5) begin bad++; $display("FAIL uncorr_latency: got %0d expected 5", lat); end
        total++; if (deg2 !== 3'd4) begin bad++; $display("FAIL uncorr_deg: got %0d expected 4", deg2); end
        total++; if (fail2 !== 1'b1) begin bad++; $display("FAIL uncorr_flag: got %b expected 1", fail2); end
        total++; if (om2 !== 16'h0) begin bad++; $display("FAIL uncorr_omega: got %h expected 0000", om2); end
    endtask

    task automatic test_single_t3();
        int lat; bit bok;
        run_job(3, 128'h010101010101, lat, bok);
        total++; if (lat !== 7) begin bad++; $display("FAIL t3_latency: got %0d expected 7", lat); end
        total++; if (lam3 !== 32'h00000101) begin bad++; $display("FAIL t3_lambda: got %h expected 00000101", lam3); end
        total++; if (om3 !== 24'h000001) begin bad++; $display("FAIL t3_omega: got %h expected 000001", om3); end
        total++; if (deg3 !== 3'd1 || fail3 !== 1'b0) begin bad++;
            $display("FAIL t3_deg: deg=%0d fail=%b expected 1/0", deg3, fail3); end
    endtask

    task automatic test_random();
        int lat, nerr, t; bit bok;
        logic [127:0] syn;
        logic [7:0]   c, got, exp;
        for (int it = 0; it < 40; it++) begin
            t = (it % 2 == 0) ? 2 : 3;
            nerr = $urandom_range(0, t);
            make_case(t, nerr);
            syn = '0;
            for (int j = 0; j < 2*t; j++) syn[8*j +: 8] = m_syn[j];
            run_job(t, syn, lat, bok);
            total++; if (lat !== ((nerr == 0) ? 1 : 2*t+1)) begin bad++;
                $display("FAIL rand_latency[%0d]: got %0d expected %0d", it, lat, (nerr == 0) ? 1 : 2*t+1); end
            total++; if (bok !== 1'b1) begin bad++; $display("FAIL rand_busy[%0d]: got %b expected 1", it, bok); end
            total++; if (cur_deg !== 3'(nerr) || cur_fail !== 1'b0) begin bad++;
                $display("FAIL rand_deg[%0d]: deg=%0d fail=%b expected %0d/0", it, cur_deg, cur_fail, nerr); end
            c = cur_lam[7:0];
            total++; if (c == 8'h00) begin bad++; $display("FAIL rand_scale[%0d]: lambda0=%h expected nonzero", it, c); end
            for (int i = 1; i <= t; i++) begin
                got = cur_lam[8*i +: 8];
                exp = gmul(c, m_lam[i]);
                total++; if (got !== exp) begin bad++;
                    $display("FAIL rand_lambda[%0d][%0d]: got %h expected %h", it, i, got, exp); end
            end
            for (int j = 0; j < t; j++) begin
                got = cur_om[8*j +: 8];
                exp = gmul(c, m_om[j]);
                total++; if (got !== exp) begin bad++;
                    $display("FAIL rand_omega[%0d][%0d]: got %h expected %h", it, j, got, exp); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int ndone, first, second;
        ndone = 0; first = -1; second = -1;
        t_sel = 2;
        @(negedge clk);
        syn2 = 32'h01010101;
        ena2 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (c == 9) ena2 = 1'b0;
            if (done2) begin
                ndone++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
        end
        $display("job back_to_back dones=%0d at %0d,%0d", ndone, first, second);
        total++; if (ndone !== 2) begin bad++; $display("FAIL b2b_count: got %0d expected 2", ndone); end
        total++; if (first !== 5 || second !== 11) begin bad++;
            $display("FAIL b2b_timing: got %0d,%0d expected 5,11", first, second); end
        total++; if (lam2 !== 24'h000101 || deg2 !== 3'd1) begin bad++;
            $display("FAIL b2b_result: lambda=%h deg=%0d expected 000101/1", lam2, deg2); end
    endtask

    task automatic test_reset_mid();
        int lat, ndone; bit bok;
        t_sel = 2;
        @(negedge clk);
        syn2 = 32'h01010101;
        ena2 = 1'b1;
        @(posedge clk); #1;
        ena2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++; if (busy2 !== 1'b0 || done2 !== 1'b0 || fail2 !== 1'b0) begin bad++;
            $display("FAIL midrst_flags: busy=%b done=%b fail=%b expected 0", busy2, done2, fail2); end
        total++; if (lam2 !== 24'h0 || om2 !== 16'h0 || deg2 !== 3'd0) begin bad++;
            $display("FAIL midrst_data: lambda=%h omega=%h deg=%0d expected 0", lam2, om2, deg2); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done2) ndone++;
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL midrst_nodone: got %0d pulses expected 0", ndone); end
        run_job(2, 128'h01010101, lat, bok);
        total++; if (lat !== 5 || lam2 !== 24'h000101 || om2 !== 16'h0001) begin bad++;
            $display("FAIL midrst_restart: lat=%0d lambda=%h omega=%h expected 5/000101/0001", lat, lam2, om2); end
    endtask

    initial begin
        rst = 1'b1; ena2 = 1'b0; ena3 = 1'b0; syn2 = '0; syn3 = '0; t_sel = 2;
        init_tables();
        test_reset();
        test_bypass();
        test_single_t2();
        test_uncorrectable();
        test_single_t3();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
